// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and a maskable irq.
// A bus write to CTRL/PRESET overrides FSM updates on the same edge, except the irq_flag set.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;
  logic        flag_set;
  logic [31:0] wmask;
  logic        wr_ctrl, wr_preset;
  logic        en, auto_reload;
  logic        unused_addr;

  assign unused_addr = ^{addr[31:4], addr[1:0]};
  assign en          = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl     = we && (|byteen) && (addr[3:2] == 2'b00);
  assign wr_preset   = we && (|byteen) && (addr[3:2] == 2'b01);

  always_comb begin
    for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{byteen[i]}};
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    flag_set = 1'b0;
    case (state_q)
      IDLE: if (en) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          // PRESET=0 also lands here, so it behaves like PRESET=1
          count_d  = '0;
          flag_set = 1'b1;
          state_d  = INT;
        end
      end
      INT: begin
        if (auto_reload) flag_d = 1'b0;
        else             ctrl_d[0] = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (wr_ctrl) begin
      ctrl_d = (ctrl_d & ~wmask[3:0]) | (wdata[3:0] & wmask[3:0]);
      flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = (preset_q & ~wmask) | (wdata & wmask);
      flag_d   = 1'b0;
    end
    if (flag_set) flag_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    case (addr[3:2])
      2'b00:   rdata = {28'd0, ctrl_q};
      2'b01:   rdata = preset_q;
      2'b10:   rdata = count_q;
      default: rdata = '0;
    endcase
  end

  assign irq = flag_q & ctrl_q[3];
endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: vector table for one-shot/mask/byte-enable flows,
// hand sequences for auto-reload, mid-count changes, collisions and async reset.
module tb_timer_counter;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] R_CTRL = 2'd0, R_PRE = 2'd1, R_CNT = 2'd2, R_NONE = 2'd3;

  timer_counter dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .byteen(byteen), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  wreg;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [1:0]  rreg;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic w, logic [1:0] wr, logic [3:0] be, logic [31:0] wd,
                              logic [1:0] rr, logic [31:0] er, logic ei);
    vec_t v;
    v.we = w; v.wreg = wr; v.be = be; v.wd = wd;
    v.rreg = rr; v.exp_rd = er; v.exp_irq = ei;
    return v;
  endfunction

  task automatic chk32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: drive (optional) write, pass the edge, release we shortly after.
  task automatic cyc(logic w, logic [1:0] r, logic [3:0] be, logic [31:0] d);
    we = w; addr = {28'd0, r, 2'b00}; byteen = be; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0; byteen = 4'h0; wdata = '0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, R_NONE, 4'h0, 32'h0);
  endtask

  task automatic rd(logic [1:0] r, output logic [31:0] v);
    addr = {28'd0, r, 2'b00};
    #1;
    v = rdata;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b0; we = 1'b0; addr = '0; byteen = 4'h0; wdata = '0;

    // Reset held with writes attempted
    for (int i = 0; i < 3; i++)
      cyc(i[0], (i == 1) ? R_PRE : R_CTRL, 4'hF, 32'hFFFF_FFFF);
    for (int r = 0; r < 4; r++) begin
      rd(r[1:0], v);
      chk32($sformatf("reset_rdata_%0d", r), v, 32'h0);
    end
    chk1("reset_irq", irq, 1'b0);
    reset = 1'b1;
    idle(1);
    rd(R_CTRL, v); chk32("post_reset_ctrl", v, 32'h0);
    rd(R_PRE, v);  chk32("post_reset_preset", v, 32'h0);

    // One-shot P=5, then mask-off run and byte-enabled PRESET write
    vecs.push_back(mk(1, R_PRE,  4'hF, 32'd5,  R_PRE,  32'd5, 0));
    vecs.push_back(mk(1, R_CTRL, 4'hF, 32'h9,  R_CTRL, 32'h9, 0)); // e0
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CTRL, 32'h9, 0)); // e1
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CNT,  32'd5, 0)); // e2
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CNT,  32'd4, 0));
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CNT,  32'd3, 0));
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CNT,  32'd2, 0));
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CNT,  32'd1, 0)); // e6
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CNT,  32'd0, 1)); // e7
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CTRL, 32'h8, 1));
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CNT,  32'd0, 1));
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CTRL, 32'h8, 1));
    vecs.push_back(mk(1, R_CTRL, 4'hF, 32'h0,  R_CTRL, 32'h0, 0));
    vecs.push_back(mk(1, R_PRE,  4'hF, 32'd1,  R_PRE,  32'd1, 0));
    vecs.push_back(mk(1, R_CTRL, 4'hF, 32'h1,  R_CTRL, 32'h1, 0));
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CNT,  32'd0, 0));
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CNT,  32'd1, 0));
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CNT,  32'd0, 0));
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CTRL, 32'h0, 0));
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_CNT,  32'd0, 0));
    vecs.push_back(mk(1, R_PRE,  4'h3, 32'hFFFF_FFFF, R_PRE, 32'h0000_FFFF, 0));
    vecs.push_back(mk(1, R_NONE, 4'hF, 32'h1234_5678, R_NONE, 32'h0, 0));
    vecs.push_back(mk(1, R_CNT,  4'hF, 32'h1234_5678, R_CNT,  32'h0, 0));
    vecs.push_back(mk(0, R_NONE, 4'h0, 32'h0,  R_PRE,  32'h0000_FFFF, 0));

    foreach (vecs[i]) begin
      cyc(vecs[i].we, vecs[i].wreg, vecs[i].be, vecs[i].wd);
      rd(vecs[i].rreg, v);
      chk32($sformatf("vec%0d_rdata", i), v, vecs[i].exp_rd);
      chk1($sformatf("vec%0d_irq", i), irq, vecs[i].exp_irq);
    end

    // Auto-reload P=2: irq for one cycle after e4, e9, e14, e19
    cyc(1, R_PRE, 4'hF, 32'd2);
    cyc(1, R_CTRL, 4'hF, 32'hB);
    for (int k = 1; k <= 21; k++) begin
      idle(1);
      chk1($sformatf("auto_irq_e%0d", k), irq, (k >= 4) && ((k - 4) % 5 == 0));
    end
    rd(R_CTRL, v); chk32("auto_ctrl", v, 32'hB);
    cyc(1, R_CTRL, 4'hF, 32'h0);
    idle(3);

    // Mid-count PRESET write, disable freeze, re-enable reload
    cyc(1, R_PRE, 4'hF, 32'd12);
    cyc(1, R_CTRL, 4'hF, 32'h1);
    idle(4);
    rd(R_CNT, v); chk32("mid_cnt10", v, 32'd10);
    cyc(1, R_PRE, 4'hF, 32'd3);
    rd(R_CNT, v); chk32("mid_cnt9", v, 32'd9);
    idle(1);
    rd(R_CNT, v); chk32("mid_cnt8", v, 32'd8);
    cyc(1, R_CTRL, 4'hF, 32'h0);
    rd(R_CNT, v); chk32("mid_cnt7", v, 32'd7);
    idle(3);
    rd(R_CNT, v); chk32("mid_frozen", v, 32'd7);
    cyc(1, R_CTRL, 4'hF, 32'h1);
    idle(1);
    rd(R_CNT, v); chk32("mid_not_resumed", v, 32'd7);
    idle(1);
    rd(R_CNT, v); chk32("mid_reload3", v, 32'd3);
    cyc(1, R_CTRL, 4'hF, 32'h0);
    idle(3);

    // CTRL write on the one-shot INT edge wins and restarts
    cyc(1, R_PRE, 4'hF, 32'd2);
    cyc(1, R_CTRL, 4'hF, 32'h9);
    idle(4);
    chk1("coll_irq_set", irq, 1'b1);
    cyc(1, R_CTRL, 4'hF, 32'h9);
    rd(R_CTRL, v); chk32("coll_ctrl", v, 32'h9);
    chk1("coll_irq_clr", irq, 1'b0);
    idle(2);
    rd(R_CNT, v); chk32("coll_reload", v, 32'd2);
    cyc(1, R_CTRL, 4'hF, 32'h0);
    idle(3);

    // Async reset while COUNT=7
    cyc(1, R_PRE, 4'hF, 32'd10);
    cyc(1, R_CTRL, 4'hF, 32'h9);
    idle(5);
    rd(R_CNT, v); chk32("rst_pre_cnt7", v, 32'd7);
    reset = 1'b0;
    #1;
    rd(R_CNT, v);  chk32("rst_async_cnt", v, 32'h0);
    rd(R_CTRL, v); chk32("rst_async_ctrl", v, 32'h0);
    chk1("rst_async_irq", irq, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // PRESET=0 acts as PRESET=1; COUNT holds at 0
    cyc(1, R_CTRL, 4'hF, 32'h9);
    idle(2);
    rd(R_CNT, v); chk32("p0_load", v, 32'd0);
    chk1("p0_irq_early", irq, 1'b0);
    idle(1);
    chk1("p0_irq", irq, 1'b1);
    idle(3);
    rd(R_CNT, v); chk32("p0_no_wrap", v, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule
